// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button debouncer family.
package btn_pkg;

    localparam int CLK_HZ             = 100_000_000;
    localparam int DEF_TICK_DIV       = CLK_HZ / 800;   // 1.25 ms sample period
    localparam int DEF_STABLE_SAMPLES = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running strobe generator: tick is high for one clk every TICK_DIV cycles,
// first tick TICK_DIV cycles after reset is released.
module debounce_tick_gen
    import btn_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == LAST);
            count <= (count == LAST) ? '0 : count + TW'(1);
        end
    end

endmodule

// File: rtl/button_debouncer_multi.sv
// N_CH-channel button debouncer with a shared sample tick; per-channel level,
// press and release pulses. Optional auto-repeat when BTN_AUTOREPEAT_EN is defined.
module button_debouncer_multi
    import btn_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int ACTIVE_LOW     = 0,
    parameter int REPEAT_DELAY   = 400,
    parameter int REPEAT_RATE    = 80
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            sample_tick
);

    localparam int CW = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RPT_DELAY_W = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_RATE_W  = RW'(REPEAT_RATE);
`endif

    debounce_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (sample_tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          s;
        logic          lvl_q;
        logic          press_q;
        logic          release_q;
        logic [CW-1:0] cnt;
        logic          accept;
        logic          rpt_hit;

        assign s      = sync2 ^ INV;
        assign accept = sample_tick && (s != lvl_q) && (cnt == CNT_LAST);

`ifdef BTN_AUTOREPEAT_EN
        logic [RW-1:0] rpt_cnt;
        logic          rpt_armed;
        logic [RW-1:0] rpt_limit;

        // First interval is REPEAT_DELAY, later ones REPEAT_RATE; a release tick never repeats.
        assign rpt_limit = rpt_armed ? RPT_RATE_W : RPT_DELAY_W;
        assign rpt_hit   = sample_tick && lvl_q && !accept && (rpt_cnt + RW'(1) == rpt_limit);

        always_ff @(posedge clk) begin
            if (rst || !lvl_q || accept) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b0;
            end else if (sample_tick) begin
                if (rpt_hit) begin
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b1;
                end else begin
                    rpt_cnt   <= rpt_cnt + RW'(1);
                end
            end
        end
`else
        // Repeat parameters are accepted but inert without auto-repeat.
        assign rpt_hit = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1     <= 1'b0;
                sync2     <= 1'b0;
                lvl_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                cnt       <= '0;
            end else begin
                sync1     <= btn_raw[i];
                sync2     <= sync1;
                press_q   <= (accept && s) || rpt_hit;
                release_q <= accept && !s;
                if (sample_tick) begin
                    if (s == lvl_q) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        lvl_q <= s;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end

        assign btn_level[i]   = lvl_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule
